// File: rtl/pwls_multi_pkg.sv
// Shared encodings for the multi-channel waveform sequencer: channel modes,
// config register addresses and the noise LFSR constants.
package pwls_multi_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_NOISE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ADDR_FREQ      = 2'd0,
        ADDR_AMP       = 2'd1,
        ADDR_MODE      = 2'd2,
        ADDR_PHASE_CLR = 2'd3
    } cfg_addr_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // Galois form: shift right, fold the taps in when a one falls out
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/pwls_wave_scale.sv
// Shared wave shaper and amplitude scaler used by every channel slot.
// Noise mode is only live when PWLS_MULTI_NOISE_EN is defined.
module pwls_wave_scale
    import pwls_multi_pkg::*;
#(
    parameter int BITS = 12
) (
    input  logic [BITS-1:0]        w,
    input  mode_e                  mode,
    input  logic [7:0]             amp,
`ifdef PWLS_MULTI_NOISE_EN
    input  logic [BITS-1:0]        noise,
`endif
    output logic signed [BITS-1:0] contrib
);

    logic [BITS-1:0]        wave;
    logic                   wave_on;
    logic signed [BITS-1:0] wave_s;
    logic signed [BITS+7:0] product;

    always_comb begin
        wave    = '0;
        wave_on = 1'b0;
        case (mode)
            MODE_SAW: begin
                wave    = w;
                wave_on = 1'b1;
            end
            MODE_SQUARE: begin
                wave    = {BITS{w[BITS-1]}};
                wave_on = 1'b1;
            end
            MODE_NOISE: begin
`ifdef PWLS_MULTI_NOISE_EN
                wave    = noise;
                wave_on = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Offset-binary to two's complement; |product| < 2^(BITS+7) so BITS+8 bits suffice
    assign wave_s  = $signed({~wave[BITS-1], wave[BITS-2:0]});
    assign product = (BITS+8)'(wave_s) * (BITS+8)'($signed({1'b0, amp}));
    assign contrib = wave_on ? BITS'(product >>> 8) : '0;

endmodule

// File: rtl/pwls_multi_channel_seq.sv
// Time-multiplexed oscillator bank: channels share one wave/scale datapath and
// are mixed into one sample per frame. Optional noise mode: PWLS_MULTI_NOISE_EN.
module pwls_multi_channel_seq
    import pwls_multi_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int CYCLES_PER_CHANNEL = 4,
    parameter int BITS               = 12,
    parameter int PHASE_BITS         = 16,
    parameter int MANTISSA_BITS      = 10,
    parameter int OCT_BITS           = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_we,
    input  logic [3:0]                                 cfg_chan,
    input  logic [1:0]                                 cfg_addr,
    input  logic [15:0]                                cfg_data,
    output logic signed [BITS+$clog2(NUM_CHANNELS)-1:0] sample_out,
    output logic                                       sample_valid,
    output logic [3:0]                                 cur_chan
);

    localparam int SUB_W  = $clog2(CYCLES_PER_CHANNEL);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ACC_W  = BITS + $clog2(NUM_CHANNELS);
    localparam int FREQ_W = OCT_BITS + MANTISSA_BITS;

    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CYCLES_PER_CHANNEL - 1);
    localparam logic [3:0]       CHAN_LAST  = 4'(NUM_CHANNELS - 1);
    localparam logic [4:0]       CHAN_COUNT = 5'(NUM_CHANNELS);

    logic [SUB_W-1:0]      sub;
    logic [PHASE_BITS-1:0] phase [NUM_CHANNELS];
    logic [FREQ_W-1:0]     freq  [NUM_CHANNELS];
    logic [7:0]            amp   [NUM_CHANNELS];
    mode_e                 mode  [NUM_CHANNELS];
    logic signed [ACC_W-1:0] acc;

    logic                    slot_end;
    logic                    frame_end;
    logic [CH_W-1:0]         cur_idx;
    logic [CH_W-1:0]         cfg_idx;
    logic                    cfg_hit;
    cfg_addr_e               cfg_sel;
    logic [PHASE_BITS-1:0]   cur_phase;
    logic [FREQ_W-1:0]       cur_freq;
    logic [PHASE_BITS-1:0]   inc;
    logic signed [BITS-1:0]  contrib;
    logic signed [ACC_W-1:0] contrib_ext;

`ifdef PWLS_MULTI_NOISE_EN
    logic [15:0] lfsr;
`endif

    assign slot_end  = (sub == SUB_LAST);
    assign frame_end = slot_end && (cur_chan == CHAN_LAST);
    assign cur_idx   = cur_chan[CH_W-1:0];
    assign cfg_idx   = cfg_chan[CH_W-1:0];
    assign cfg_hit   = cfg_we && ({1'b0, cfg_chan} < CHAN_COUNT);
    assign cfg_sel   = cfg_addr_e'(cfg_addr);

    assign cur_phase = phase[cur_idx];
    assign cur_freq  = freq[cur_idx];
    // Increment {1,mantissa} << oct wraps naturally in the phase width
    assign inc = PHASE_BITS'({1'b1, cur_freq[MANTISSA_BITS-1:0]}) << cur_freq[FREQ_W-1 -: OCT_BITS];

    // Slot and channel counters define the frame schedule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub      <= '0;
            cur_chan <= '0;
        end else if (slot_end) begin
            sub      <= '0;
            cur_chan <= (cur_chan == CHAN_LAST) ? 4'd0 : cur_chan + 4'd1;
        end else begin
            sub <= sub + SUB_W'(1);
        end
    end

    // Per-channel configuration; writes land one cycle after the strobe, so a
    // write during a channel's update cycle only affects its next update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                freq[i] <= '0;
                amp[i]  <= '0;
                mode[i] <= MODE_OFF;
            end
        end else if (cfg_hit) begin
            case (cfg_sel)
                ADDR_FREQ: freq[cfg_idx] <= FREQ_W'(cfg_data);
                ADDR_AMP:  amp[cfg_idx]  <= 8'(cfg_data);
                ADDR_MODE: mode[cfg_idx] <= mode_e'(2'(cfg_data));
                default:   ;
            endcase
        end
    end

    // Phase accumulators; a clear beats a same-cycle advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (cfg_hit && (cfg_sel == ADDR_PHASE_CLR) && (cfg_idx == CH_W'(i))) begin
                    phase[i] <= '0;
                end else if (slot_end && (cur_idx == CH_W'(i))) begin
                    phase[i] <= phase[i] + inc;
                end
            end
        end
    end

    pwls_wave_scale #(
        .BITS (BITS)
    ) u_wave_scale (
        .w       (cur_phase[PHASE_BITS-1 -: BITS]),
        .mode    (mode[cur_idx]),
        .amp     (amp[cur_idx]),
`ifdef PWLS_MULTI_NOISE_EN
        .noise   (lfsr[BITS-1:0]),
`endif
        .contrib (contrib)
    );

    assign contrib_ext = ACC_W'(contrib);

    // Mixer: the last channel's contribution goes straight into the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= frame_end;
            if (frame_end) begin
                sample_out <= acc + contrib_ext;
                acc        <= '0;
            end else if (slot_end) begin
                acc <= acc + contrib_ext;
            end
        end
    end

`ifdef PWLS_MULTI_NOISE_EN
    // One noise word per frame, shared by all channels in noise mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (frame_end) begin
            lfsr <= lfsr_step(lfsr);
        end
    end
`endif

endmodule

// File: tb/tb_pwls_multi_channel_seq.sv
// Self-checking bench for pwls_multi_channel_seq (default parameters): table of
// single-channel vectors plus hand-written multi-cycle sequences.
module tb_pwls_multi_channel_seq;
    import pwls_multi_pkg::*;

    localparam int OW = 14;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [3:0]           cfg_chan = '0;
    logic [1:0]           cfg_addr = '0;
    logic [15:0]          cfg_data = '0;
    logic signed [OW-1:0] sample_out;
    logic                 sample_valid;
    logic [3:0]           cur_chan;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  chan;
        logic [15:0] freq;
        logic [15:0] amp;
        logic [15:0] mode;
        int          e0;
        int          e1;
        int          e2;
    } vec_t;

    vec_t vecs [7];

    pwls_multi_channel_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_chan     (cfg_chan),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .cur_chan     (cur_chan)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int t);
        while (cyc < t) step();
    endtask

    task automatic doReset();
        cfg_we = 1'b0;
        rst_n  = 1'b0;
        #13;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] ch, input logic [1:0] addr,
                                 input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_chan = ch;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    // Test sequence
    initial begin
        vecs[0] = '{chan: 4'd1, freq: 16'h0000, amp: 16'd255, mode: 16'd1,
                    e0: -2040, e1: -1977, e2: -1913};
        vecs[1] = '{chan: 4'd2, freq: 16'h1400, amp: 16'd128, mode: 16'd2,
                    e0: -1024, e1: 1023, e2: -1024};
        vecs[2] = '{chan: 4'd3, freq: 16'h0000, amp: 16'd255, mode: 16'd0,
                    e0: 0, e1: 0, e2: 0};
        vecs[3] = '{chan: 4'd1, freq: 16'h03FF, amp: 16'd16, mode: 16'd1,
                    e0: -128, e1: -121, e2: -113};
`ifdef PWLS_MULTI_NOISE_EN
        vecs[4] = '{chan: 4'd3, freq: 16'h0000, amp: 16'd255, mode: 16'd3,
                    e0: -2040, e1: -1020, e2: 510};
`else
        vecs[4] = '{chan: 4'd3, freq: 16'h0000, amp: 16'd255, mode: 16'd3,
                    e0: 0, e1: 0, e2: 0};
`endif
        vecs[5] = '{chan: 4'd1, freq: 16'h1C00, amp: 16'd255, mode: 16'd1,
                    e0: -2040, e1: -2040, e2: -2040};
        vecs[6] = '{chan: 4'd1, freq: 16'hFFFF, amp: 16'hA5FF, mode: 16'hFFF9,
                    e0: -2040, e1: 2032, e2: 2024};

        // Reset values and frame cadence
        #2 rst_n = 1'b0;
        #3;
        checkOutput("rst_sample_out", sample_out, 0);
        checkOutput("rst_sample_valid", sample_valid, 0);
        checkOutput("rst_cur_chan", cur_chan, 0);
        doReset();
        runTo(4);
        checkOutput("cad_chan_at4", cur_chan, 1);
        runTo(15);
        checkOutput("cad_chan_at15", cur_chan, 3);
        checkOutput("cad_valid_at15", sample_valid, 0);
        runTo(16);
        checkOutput("cad_valid_at16", sample_valid, 1);
        checkOutput("cad_sample_off", sample_out, 0);
        checkOutput("cad_chan_at16", cur_chan, 0);
        runTo(17);
        checkOutput("cad_valid_at17", sample_valid, 0);
        runTo(31);
        checkOutput("cad_valid_at31", sample_valid, 0);
        runTo(32);
        checkOutput("cad_valid_at32", sample_valid, 1);

        // Single-channel vectors
        for (int i = 0; i < 7; i++) begin
            doReset();
            applyStimulus(vecs[i].chan, ADDR_FREQ, vecs[i].freq);
            applyStimulus(vecs[i].chan, ADDR_AMP, vecs[i].amp);
            applyStimulus(vecs[i].chan, ADDR_MODE, vecs[i].mode);
            runTo(15);
            checkOutput($sformatf("vec%0d_valid15", i), sample_valid, 0);
            runTo(16);
            checkOutput($sformatf("vec%0d_valid16", i), sample_valid, 1);
            checkOutput($sformatf("vec%0d_frame1", i), sample_out, vecs[i].e0);
            runTo(32);
            checkOutput($sformatf("vec%0d_frame2", i), sample_out, vecs[i].e1);
            runTo(48);
            checkOutput($sformatf("vec%0d_frame3", i), sample_out, vecs[i].e2);
        end

        // Phase advance by 1024 per frame and wrap after 64 frames
        doReset();
        applyStimulus(4'd0, ADDR_FREQ, 16'h0000);
        runTo(16);
        checkOutput("phase0_f1", dut.phase[0], 1024);
        runTo(16 * 63);
        checkOutput("phase0_f63", dut.phase[0], 64512);
        runTo(16 * 64);
        checkOutput("phase0_f64", dut.phase[0], 0);

        // Phase clear coinciding with channel 2's update
        doReset();
        runTo(16);
        checkOutput("clr_before", dut.phase[2], 1024);
        runTo(27);
        applyStimulus(4'd2, ADDR_PHASE_CLR, 16'h0000);
        checkOutput("clr_wins", dut.phase[2], 0);
        runTo(44);
        checkOutput("clr_resume", dut.phase[2], 1024);

        // Writes to a channel that does not exist
        doReset();
        applyStimulus(4'd7, ADDR_AMP, 16'h00FF);
        applyStimulus(4'd7, ADDR_MODE, 16'h0001);
        applyStimulus(4'd7, ADDR_FREQ, 16'h1400);
        runTo(15);
        applyStimulus(4'd7, ADDR_PHASE_CLR, 16'h0000);
        checkOutput("bad_chan_phase3", dut.phase[3], 1024);
        checkOutput("bad_chan_sample1", sample_out, 0);
        runTo(32);
        checkOutput("bad_chan_phase3_f2", dut.phase[3], 2048);
        checkOutput("bad_chan_sample2", sample_out, 0);

        // Mixing two channels, amp write during channel 2's update cycle
        doReset();
        applyStimulus(4'd0, ADDR_AMP, 16'd255);
        applyStimulus(4'd0, ADDR_MODE, 16'd2);
        applyStimulus(4'd2, ADDR_AMP, 16'd128);
        applyStimulus(4'd2, ADDR_MODE, 16'd1);
        runTo(16);
        checkOutput("mix_frame1", sample_out, -3064);
        runTo(27);
        applyStimulus(4'd2, ADDR_AMP, 16'd255);
        runTo(32);
        checkOutput("mix_frame2", sample_out, -3032);
        runTo(48);
        checkOutput("mix_frame3", sample_out, -3953);

        // Reset mid-frame clears outputs at once and drops the partial sum
        doReset();
        applyStimulus(4'd1, ADDR_AMP, 16'd255);
        applyStimulus(4'd1, ADDR_MODE, 16'd1);
        runTo(16);
        checkOutput("mid_pre_sample", sample_out, -2040);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_valid_async", sample_valid, 0);
        checkOutput("mid_sample_async", sample_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        applyStimulus(4'd1, ADDR_AMP, 16'd255);
        applyStimulus(4'd1, ADDR_MODE, 16'd1);
        runTo(26);
        rst_n = 1'b0;
        #2;
        checkOutput("mid2_sample_async", sample_out, 0);
        checkOutput("mid2_chan_async", cur_chan, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        runTo(16);
        checkOutput("mid2_valid_after", sample_valid, 1);
        checkOutput("mid2_partial_dropped", sample_out, 0);

`ifdef PWLS_MULTI_NOISE_EN
        // LFSR steps once per frame from its seed
        doReset();
        runTo(15);
        checkOutput("lfsr_seed", dut.lfsr, 16'h0001);
        runTo(16);
        checkOutput("lfsr_step1", dut.lfsr, 16'hB400);
        runTo(32);
        checkOutput("lfsr_step2", dut.lfsr, 16'h5A00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
